store_fifo_bridge: RTL and testbench

- Memory-mapped store sink downstream of the TOP_V0 processor core.
- Snoops the core's data-side store bus (MemWrite, DataAdr, WriteData) and captures stores to a small address window into a FIFO.
- Drains captured words to a peripheral over a valid/ready stream.
- The core cannot stall. On overflow the block drops the store and flags it, so the core never waits.

---
 rtl/store_bridge_pkg.sv | 9 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/store_fifo_bridge.sv | 71 +++++++
 tb/tb_store_fifo_bridge.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/store_bridge_pkg.sv
// Shared constants for the store-to-stream bridge: register offsets,
// control-register bit positions and the drop counter width.
package store_bridge_pkg;
  localparam logic [31:0] DATA_OFF     = 32'd0;
  localparam logic [31:0] CTRL_OFF     = 32'd4;
  localparam int unsigned CTRL_CLR_OVF = 0;
  localparam int unsigned CTRL_FLUSH   = 1;
  localparam int unsigned DROP_CNT_W   = 8;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with separate occupancy counter; a push into a
// full FIFO is still taken when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // Gate the head so a stale entry is never visible once the FIFO is empty.
  assign head    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/store_fifo_bridge.sv
// Captures core stores to a two-word window into a FIFO and drains them over a
// valid/ready stream; stores that find the FIFO full are dropped and counted.
module store_fifo_bridge
  import store_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWrite,
  input  logic [31:0]             DataAdr,
  input  logic [DATA_W-1:0]       WriteData,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);
  localparam logic [31:0] DATA_ADDR = BASE_ADDR + DATA_OFF;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + CTRL_OFF;

  logic data_hit;
  logic ctrl_hit;
  logic pop;
  logic flush;
  logic clr_ovf;
  logic drop;
  logic full;
  logic empty;

  // Full 32-bit compare also rejects misaligned addresses inside the window.
  assign data_hit = MemWrite & (DataAdr == DATA_ADDR);
  assign ctrl_hit = MemWrite & (DataAdr == CTRL_ADDR);
  assign flush    = ctrl_hit & WriteData[CTRL_FLUSH];
  assign clr_ovf  = ctrl_hit & WriteData[CTRL_CLR_OVF];
  assign out_valid = ~empty;
  assign pop      = out_valid & out_ready;
  assign drop     = data_hit & full & ~pop;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (data_hit),
    .pop   (pop),
    .flush (flush),
    .din   (WriteData),
    .head  (out_data),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_store_fifo_bridge.sv
// Directed bench for store_fifo_bridge: capture, overflow/saturation,
// full-with-pop, address filtering, control register and async reset.
module tb_store_fifo_bridge;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  store_fifo_bridge #(
    .BASE_ADDR (BASE),
    .DEPTH     (8),
    .DATA_W    (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One store on the next rising edge; returns 1 ns after that edge.
  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    @(posedge clk); #1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // single capture, visible right after the capturing edge
    store(BASE, 32'd7);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", out_data, 32'd7);
    chk("t1_count", 32'(fifo_count), 32'd1);
    out_ready = 1'b1; idle_cycle(); out_ready = 1'b0;
    chk("t1_empty", 32'(out_valid), 32'd0);

    // fill, overflow by one, then drain in order
    for (int i = 1; i <= 8; i++) store(BASE, 32'(i));
    chk("t2_full", 32'(fifo_count), 32'd8);
    store(BASE, 32'd9);
    chk("t2_count", 32'(fifo_count), 32'd8);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    chk("t2_head", out_data, 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain", out_data, 32'(i));
      idle_cycle();
    end
    out_ready = 1'b0;
    chk("t2_valid_after", 32'(out_valid), 32'd0);
    chk("t2_count_after", 32'(fifo_count), 32'd0);

    store(BASE + 32'd4, 32'd1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // full with a simultaneous pop accepts the new word
    for (int i = 1; i <= 8; i++) store(BASE, 32'(i));
    out_ready = 1'b1;
    store(BASE, 32'd9);
    out_ready = 1'b0;
    chk("t3_count", 32'(fifo_count), 32'd8);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_drop", 32'(drop_cnt), 32'd0);
    chk("t3_head", out_data, 32'd2);
    out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      chk("t3_drain", out_data, 32'(i));
      idle_cycle();
    end
    out_ready = 1'b0;
    chk("t3_valid_after", 32'(out_valid), 32'd0);

    // stores that must be ignored
    store(BASE + 32'd1, 32'd11);
    store(BASE + 32'd8, 32'd12);
    store(32'd100, 32'd13);
    DataAdr = BASE; WriteData = 32'd14; idle_cycle(); DataAdr = '0; WriteData = '0;
    chk("t4_count", 32'(fifo_count), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_valid", 32'(out_valid), 32'd0);

    // drop counter saturation, partial drain, then clear+flush
    for (int i = 1; i <= 8; i++) store(BASE, 32'(i));
    for (int i = 0; i < 260; i++) store(BASE, 32'hdead);
    chk("t5_sat", 32'(drop_cnt), 32'd255);
    chk("t5_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    repeat (5) idle_cycle();
    out_ready = 1'b0;
    chk("t5_count3", 32'(fifo_count), 32'd3);
    chk("t5_head", out_data, 32'd6);
    store(BASE + 32'd4, 32'd3);
    chk("t5_flush_count", 32'(fifo_count), 32'd0);
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    chk("t5_clr_ovf", 32'(overflow), 32'd0);
    chk("t5_clr_drop", 32'(drop_cnt), 32'd0);
    chk("t5_data", out_data, 32'd0);

    // asynchronous reset between edges with words queued
    for (int i = 10; i <= 13; i++) store(BASE, 32'(i));
    chk("t6_count4", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    idle_cycle();
    chk("t6_head", out_data, 32'd11);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_data", out_data, 32'd0);
    out_ready = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    store(BASE, 32'd5);
    chk("t6_recover_data", out_data, 32'd5);
    chk("t6_recover_count", 32'(fifo_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
